// File: rtl/track_filter.sv
// track_filter: per-frame EMA smoothing, motion direction and track/lost status
// for the first-marker detector's hits; all outputs refresh one clock after end_frame.
module track_filter #(
    parameter int ALPHA_SHIFT = 2,
    parameter int DEADZONE    = 4,
    parameter int LOST_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        detect,
    input  logic [12:0] i_X_pos,
    input  logic [12:0] i_Y_pos,
    input  logic        new_frame,
    input  logic        end_frame,
    output logic        o_update,
    output logic        o_tracking,
    output logic        o_lost,
    output logic [12:0] o_X_avg,
    output logic [12:0] o_Y_avg,
    output logic [3:0]  o_dir,
    output logic [7:0]  o_miss_cnt
);
    typedef enum logic {IDLE, TRACK} state_t;
    localparam logic signed [13:0] DZ = 14'(DEADZONE);
    localparam logic [7:0] LF = 8'(LOST_FRAMES);
    state_t state, state_n;
    logic in_frame, hit, acc, eval, f_hit, tracking_n, lost_n;
    logic [12:0] sx, sy, px, py, fx, fy, ax_n, ay_n, px_n, py_n;
    logic signed [13:0] ex, ey, dx, dy;
    logic [3:0] dir_n;
    logic [7:0] miss_n;
    always_comb begin
        acc = detect & (in_frame | new_frame);
        eval = end_frame & in_frame & ~new_frame;
        f_hit = hit | acc;
        // a detect in the end_frame cycle is folded in without waiting for the latch
        fx = hit ? sx : i_X_pos;
        fy = hit ? sy : i_Y_pos;
        ex = $signed({1'b0, fx}) - $signed({1'b0, o_X_avg});
        ey = $signed({1'b0, fy}) - $signed({1'b0, o_Y_avg});
        dx = $signed({1'b0, fx}) - $signed({1'b0, px});
        dy = $signed({1'b0, fy}) - $signed({1'b0, py});
        state_n = state;
        tracking_n = o_tracking;
        lost_n = 1'b0;
        ax_n = o_X_avg;
        ay_n = o_Y_avg;
        px_n = px;
        py_n = py;
        dir_n = o_dir;
        miss_n = o_miss_cnt;
        if (eval && f_hit) begin
            state_n = TRACK;
            tracking_n = 1'b1;
            miss_n = 8'd0;
            px_n = fx;
            py_n = fy;
            ax_n = (state == IDLE) ? fx : o_X_avg + 13'(ex >>> ALPHA_SHIFT);
            ay_n = (state == IDLE) ? fy : o_Y_avg + 13'(ey >>> ALPHA_SHIFT);
            dir_n = (state == IDLE) ? 4'd0 : {dy < -DZ, dy > DZ, dx < -DZ, dx > DZ};
        end else if (eval && state == TRACK) begin
            miss_n = o_miss_cnt + 8'd1;
            dir_n = 4'd0;
            if (miss_n == LF) begin
                state_n = IDLE;
                tracking_n = 1'b0;
                lost_n = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            in_frame <= 1'b0;
            hit <= 1'b0;
            sx <= '0;
            sy <= '0;
            px <= '0;
            py <= '0;
            o_update <= 1'b0;
            o_tracking <= 1'b0;
            o_lost <= 1'b0;
            o_X_avg <= '0;
            o_Y_avg <= '0;
            o_dir <= '0;
            o_miss_cnt <= '0;
        end else begin
            state <= state_n;
            in_frame <= new_frame ? 1'b1 : (end_frame ? 1'b0 : in_frame);
            hit <= new_frame ? acc : (hit | acc);
            if (acc && (new_frame || !hit)) begin
                sx <= i_X_pos;
                sy <= i_Y_pos;
            end
            px <= px_n;
            py <= py_n;
            o_update <= eval;
            o_tracking <= tracking_n;
            o_lost <= lost_n;
            o_X_avg <= ax_n;
            o_Y_avg <= ay_n;
            o_dir <= dir_n;
            o_miss_cnt <= miss_n;
        end
    end
endmodule

// File: tb/tb_track_filter.sv
// tb_track_filter: directed test-plan frames plus randomized frames checked
// against a per-frame behavioural model of the tracker.
module tb_track_filter;
    localparam int A = 2, DZ = 4, LF = 8;
    logic clk = 1'b0, rst = 1'b1, detect = 1'b0, new_frame = 1'b0, end_frame = 1'b0;
    logic [12:0] i_X_pos = '0, i_Y_pos = '0;
    logic o_update, o_tracking, o_lost;
    logic [12:0] o_X_avg, o_Y_avg;
    logic [3:0] o_dir;
    logic [7:0] o_miss_cnt;
    int n_chk = 0, n_err = 0;
    bit m_track, m_lost;
    int m_ax, m_ay, m_px, m_py, m_dir, m_miss;

    track_filter #(.ALPHA_SHIFT(A), .DEADZONE(DZ), .LOST_FRAMES(LF)) dut (
        .clk(clk), .rst(rst), .detect(detect), .i_X_pos(i_X_pos), .i_Y_pos(i_Y_pos),
        .new_frame(new_frame), .end_frame(end_frame), .o_update(o_update),
        .o_tracking(o_tracking), .o_lost(o_lost), .o_X_avg(o_X_avg), .o_Y_avg(o_Y_avg),
        .o_dir(o_dir), .o_miss_cnt(o_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_track = 0; m_lost = 0;
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_dir = 0; m_miss = 0;
    endtask

    task automatic model_step(input bit h, input int x, input int y);
        int dx, dy;
        m_lost = 0;
        if (h) begin
            dx = x - m_px;
            dy = y - m_py;
            if (!m_track) begin
                m_ax = x; m_ay = y; m_dir = 0;
            end else begin
                m_ax = m_ax + ((x - m_ax) >>> A);
                m_ay = m_ay + ((y - m_ay) >>> A);
                m_dir = 8 * int'(dy < -DZ) + 4 * int'(dy > DZ) + 2 * int'(dx < -DZ) + int'(dx > DZ);
            end
            m_px = x; m_py = y; m_miss = 0; m_track = 1;
        end else if (m_track) begin
            m_miss++;
            m_dir = 0;
            if (m_miss == LF) begin
                m_track = 0;
                m_lost = 1;
            end
        end
    endtask

    task automatic check_all(input bit upd);
        chk("update", int'(o_update), int'(upd));
        chk("tracking", int'(o_tracking), int'(m_track));
        chk("lost", int'(o_lost), int'(upd & m_lost));
        chk("x_avg", int'(o_X_avg), m_ax);
        chk("y_avg", int'(o_Y_avg), m_ay);
        chk("dir", int'(o_dir), m_dir);
        chk("miss_cnt", int'(o_miss_cnt), m_miss);
    endtask

    // Five-cycle frame; first detect at cycle k, optional later detect at (x2,y2),
    // preceded by a stray out-of-frame detect that must be ignored.
    task automatic frame(input bit h, input int x, input int y, input int k,
                         input bit two, input int x2, input int y2);
        int k2;
        k2 = (h && two && k < 4) ? int'($urandom_range(k + 1, 4)) : -1;
        detect = 1; i_X_pos = 13'($urandom); i_Y_pos = 13'($urandom);
        tick;
        for (int c = 0; c < 5; c++) begin
            new_frame = (c == 0);
            end_frame = (c == 4);
            detect = h && (c == k || c == k2);
            i_X_pos = (c == k2) ? 13'(x2) : (c == k) ? 13'(x) : 13'($urandom);
            i_Y_pos = (c == k2) ? 13'(y2) : (c == k) ? 13'(y) : 13'($urandom);
            tick;
        end
        new_frame = 0; end_frame = 0; detect = 0;
        model_step(h, x, y);
        check_all(1);
        tick;
        chk("update_one_cycle", int'(o_update), 0);
        chk("lost_one_cycle", int'(o_lost), 0);
    endtask

    task automatic hit_frame(input int x, input int y);
        frame(1, x, y, int'($urandom_range(0, 4)), 0, 0, 0);
    endtask

    task automatic miss_frame;
        frame(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int x, y;
        bit h;
        model_reset;
        tick; tick;
        rst = 0;
        check_all(0);
        miss_frame;
        miss_frame;
        hit_frame(100, 200);
        chk("first_x", int'(o_X_avg), 100);
        hit_frame(140, 180);
        chk("ema_x", int'(o_X_avg), 110);
        chk("ema_y", int'(o_Y_avg), 195);
        chk("dir_up_right", int'(o_dir), 4'b1001);
        frame(1, 50, 60, 1, 1, 300, 300);
        frame(1, 70, 70, 4, 0, 0, 0);
        hit_frame(110, 195);
        for (int i = 0; i < LF; i++) miss_frame;
        chk("lost_miss_cnt", int'(o_miss_cnt), LF);
        miss_frame;
        hit_frame(20, 20);
        chk("reacquire_x", int'(o_X_avg), 20);
        hit_frame(100, 100);
        hit_frame(104, 96);
        chk("deadzone_dir", int'(o_dir), 0);
        // frame abandoned by a second new_frame: no update, its detect is dropped
        new_frame = 1; detect = 1; i_X_pos = 13'd500; i_Y_pos = 13'd500;
        tick;
        new_frame = 0; detect = 0;
        tick;
        chk("abandon_no_update", int'(o_update), 0);
        new_frame = 1;
        tick;
        new_frame = 0;
        chk("abandon_no_update2", int'(o_update), 0);
        tick;
        end_frame = 1;
        tick;
        end_frame = 0;
        model_step(0, 0, 0);
        check_all(1);
        tick;
        // reset mid-frame after a detect
        hit_frame(200, 300);
        new_frame = 1; detect = 1; i_X_pos = 13'd9; i_Y_pos = 13'd9;
        tick;
        new_frame = 0; detect = 0;
        tick;
        rst = 1;
        tick;
        rst = 0;
        model_reset;
        check_all(0);
        end_frame = 1;
        tick;
        end_frame = 0;
        chk("post_rst_endframe", int'(o_update), 0);
        tick;
        hit_frame(33, 44);
        chk("post_rst_x", int'(o_X_avg), 33);
        for (int i = 0; i < 200; i++) begin
            h = $urandom_range(0, 9) < (((i / 20) % 2) ? 2 : 8);
            x = $urandom_range(0, 1) ? int'($urandom_range(0, 8191)) : (m_px + int'($urandom_range(0, 16)) - 8) & 8191;
            y = $urandom_range(0, 1) ? int'($urandom_range(0, 8191)) : (m_py + int'($urandom_range(0, 16)) - 8) & 8191;
            frame(h, x, y, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
